// File: rtl/data_bus_pkg.sv
// rtl/data_bus_pkg.sv - state codes, size codes and helpers for the data bus controller
package data_bus_pkg;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FLASH     = 3'd1;
  localparam state_t ST_RAM_WR    = 3'd2;
  localparam state_t ST_RAM_RD    = 3'd3;
  localparam state_t ST_RAM_DRAIN = 3'd4;
  localparam state_t ST_RESP_ERR  = 3'd5;

  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;
  localparam size_t SZ_BAD  = 2'd3;

  // Number of 8-bit RAM beats needed for an access of the given size
  function automatic logic [2:0] beat_count(input size_t size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Pick the addressed byte/half lane out of a 32-bit word and zero-extend it
  function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] lane,
                                              input size_t size);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: res = {24'h0, shifted[7:0]};
      SZ_HALF: res = {16'h0, shifted[15:0]};
      default: res = shifted;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - region hit, alignment and offset decode for one bus address
module bus_decode
  import data_bus_pkg::*;
#(
  parameter int unsigned FLASH_WIDTH = 9,
  parameter int unsigned RAM_WIDTH   = 10,
  parameter logic [31:0] FLASH_BASE  = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter int unsigned OFF_W       = 11
) (
  input  logic [31:0]      addr,
  input  logic [1:0]       size,
  output logic             hit_flash,
  output logic             hit_ram,
  output logic             misaligned,
  output logic [OFF_W-1:0] offset
);

  logic [31:0] flash_off;
  logic [31:0] ram_off;

  // Bases are region-aligned, so an address hits when its offset fits the region width
  always_comb begin
    flash_off  = addr - FLASH_BASE;
    ram_off    = addr - RAM_BASE;
    hit_flash  = (flash_off >> (FLASH_WIDTH + 2)) == 32'd0;
    hit_ram    = (ram_off >> RAM_WIDTH) == 32'd0;
    misaligned = ((size == SZ_HALF) && addr[0]) ||
                 ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    offset     = hit_flash ? flash_off[OFF_W-1:0] : ram_off[OFF_W-1:0];
  end

endmodule

// File: rtl/data_bus_ctrl.sv
// rtl/data_bus_ctrl.sv - single-master bus controller for word flash and byte-wide RAM
module data_bus_ctrl
  import data_bus_pkg::*;
#(
  parameter int unsigned FLASH_WIDTH = 9,
  parameter int unsigned RAM_WIDTH   = 10,
  parameter logic [31:0] FLASH_BASE  = 32'h0000_0000,
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [FLASH_WIDTH-1:0] flash_addr,
  input  logic [31:0]            flash_data,
  output logic                   ram_rw,
  output logic [RAM_WIDTH-1:0]   ram_addr,
  output logic [7:0]             ram_di,
  input  logic [7:0]             ram_do
);

  localparam int unsigned OFF_W = (FLASH_WIDTH + 2 > RAM_WIDTH) ? FLASH_WIDTH + 2 : RAM_WIDTH;

  logic             hit_flash, hit_ram, misaligned;
  logic [OFF_W-1:0] offset;

  bus_decode #(
    .FLASH_WIDTH(FLASH_WIDTH), .RAM_WIDTH(RAM_WIDTH),
    .FLASH_BASE(FLASH_BASE), .RAM_BASE(RAM_BASE), .OFF_W(OFF_W)
  ) u_decode (
    .addr(req_addr), .size(req_size),
    .hit_flash(hit_flash), .hit_ram(hit_ram), .misaligned(misaligned), .offset(offset)
  );

  state_t                 state_q, state_d;
  size_t                  size_q, size_d;
  logic [1:0]             lane_q, lane_d;
  logic [1:0]             beat_q, beat_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [RAM_WIDTH-1:0]   offset_q, offset_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   ram_rw_q, ram_rw_d;
  logic [RAM_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]             ram_di_q, ram_di_d;
  logic [FLASH_WIDTH-1:0] flash_addr_q, flash_addr_d;

  logic [1:0] next_beat;
  logic       last_beat;

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign ram_rw     = ram_rw_q;
  assign ram_addr   = ram_addr_q;
  assign ram_di     = ram_di_q;
  assign flash_addr = flash_addr_q;

  assign next_beat = beat_q + 2'd1;
  assign last_beat = ({1'b0, beat_q} == (beat_count(size_q) - 3'd1));

  // Next-state logic: accept/classify in IDLE, then sequence flash or RAM beats
  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    lane_d       = lane_q;
    beat_d       = beat_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    offset_d     = offset_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = 32'h0;
    ram_rw_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_di_d     = ram_di_q;
    flash_addr_d = flash_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d   = req_size;
          lane_d   = offset[1:0];
          beat_d   = 2'd0;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          offset_d = offset[RAM_WIDTH-1:0];
          if ((req_size == SZ_BAD) || misaligned || !(hit_flash || hit_ram) ||
              (hit_flash && req_we)) begin
            state_d = ST_RESP_ERR;
          end else if (hit_flash) begin
            state_d      = ST_FLASH;
            flash_addr_d = offset[FLASH_WIDTH+1:2];
          end else if (req_we) begin
            state_d    = ST_RAM_WR;
            ram_rw_d   = 1'b1;
            ram_addr_d = offset[RAM_WIDTH-1:0];
            ram_di_d   = req_wdata[7:0];
          end else begin
            state_d    = ST_RAM_RD;
            ram_addr_d = offset[RAM_WIDTH-1:0];
          end
        end
      end
      ST_FLASH: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = lane_select(flash_data, lane_q, size_q);
        state_d     = ST_IDLE;
      end
      ST_RESP_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RAM_WR: begin
        if (last_beat) begin
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          beat_d     = next_beat;
          ram_rw_d   = 1'b1;
          ram_addr_d = offset_q + RAM_WIDTH'(next_beat);
          ram_di_d   = wdata_q[{next_beat, 3'b000} +: 8];
        end
      end
      ST_RAM_RD: begin
        // ram_do now holds the byte whose address was sampled on the previous edge
        if (beat_q != 2'd0) rdata_d[{beat_q - 2'd1, 3'b000} +: 8] = ram_do;
        if (last_beat) begin
          state_d = ST_RAM_DRAIN;
        end else begin
          beat_d     = next_beat;
          ram_addr_d = offset_q + RAM_WIDTH'(next_beat);
        end
      end
      ST_RAM_DRAIN: begin
        rdata_d[{beat_q, 3'b000} +: 8] = ram_do;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata_d;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      size_q       <= SZ_BYTE;
      lane_q       <= 2'd0;
      beat_q       <= 2'd0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      offset_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_di_q     <= 8'h0;
      flash_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      beat_q       <= beat_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      offset_q     <= offset_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      ram_rw_q     <= ram_rw_d;
      ram_addr_q   <= ram_addr_d;
      ram_di_q     <= ram_di_d;
      flash_addr_q <= flash_addr_d;
    end
  end

endmodule
